// File: rtl/scan_bist_pkg.sv
// Shared types and constants for the logic-BIST scan controller.
package scan_bist_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCapture,
    StUnload,
    StDone
  } state_e;

  localparam int unsigned DefLfsrW    = 16;
  localparam int unsigned DefMisrW    = 16;
  localparam logic [15:0] DefLfsrSeed = 16'hACE1;
  localparam logic [15:0] DefLfsrPoly = 16'hB400;
  localparam logic [15:0] DefMisrPoly = 16'hB400;

  // Widest register the reference helpers handle; narrower values live in the low bits.
  localparam int unsigned MaxW = 32;
  typedef logic [MaxW-1:0] word_t;

  // One Galois LFSR step: shift right, fold the feedback mask in when bit 0 falls out.
  function automatic word_t lfsr_step(input word_t v, input word_t poly);
    return (v >> 1) ^ (v[0] ? poly : '0);
  endfunction

  // One MISR step: LFSR step, then the serial input is XORed into the MSB of a width-bit register.
  function automatic word_t misr_step(input word_t v, input word_t poly, input logic din,
                                      input int unsigned width);
    return lfsr_step(v, poly) ^ (word_t'(din) << (width - 1));
  endfunction

endpackage

// File: rtl/scan_lfsr_misr.sv
// Galois shift register with load, enable and a serial XOR input into the MSB.
// Tie din_i low to use it as a pattern LFSR; drive it to use it as a MISR.
module scan_lfsr_misr #(
  parameter int unsigned      Width  = 16,
  parameter logic [Width-1:0] Poly   = '0,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [Width-1:0] d_o,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q, q_d, step;

  // Next value: load wins over a step, otherwise hold.
  always_comb begin
    step = (q_q >> 1) ^ (q_q[0] ? Poly : '0) ^ {din_i, {(Width-1){1'b0}}};
    q_d  = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = step;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign d_o = q_d;
  assign q_o = q_q;

endmodule

// File: rtl/scan_bist_ctrl.sv
// Logic-BIST scan controller: drives SE/SI into a scan chain from an LFSR and
// compacts the chain's scan-out into a MISR signature, one signature per run.
module scan_bist_ctrl
  import scan_bist_pkg::*;
#(
  parameter int unsigned       CHAIN_LEN = 32,
  parameter int unsigned       PATTERNS  = 16,
  parameter int unsigned       LFSR_W    = DefLfsrW,
  parameter int unsigned       MISR_W    = DefMisrW,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DefLfsrSeed),
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DefLfsrPoly),
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DefMisrPoly)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic                              so_i,
  output logic                              se_o,
  output logic                              si_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [MISR_W-1:0]                 signature_o,
  output logic [$clog2(PATTERNS+1)-1:0]     pat_cnt_o
);

  localparam int unsigned      CntW      = $clog2(CHAIN_LEN);
  localparam int unsigned      PatW      = $clog2(PATTERNS + 1);
  localparam logic [CntW-1:0]  LastShift = CntW'(CHAIN_LEN - 1);
  localparam logic [PatW-1:0]  LastPat   = PatW'(PATTERNS - 1);

  state_e            state_q;
  logic              se_q, si_q;
  logic [CntW-1:0]   cnt_q;
  logic [PatW-1:0]   pat_cnt_q;

  logic              start_go;
  logic              lfsr_en, misr_en;
  logic [LFSR_W-1:0] lfsr_d, lfsr_q;
  logic [MISR_W-1:0] misr_d, misr_q;

  // Register control: a run may start only from IDLE/DONE, and ABORT freezes both registers.
  always_comb begin
    start_go = start_i && !abort_i && ((state_q == StIdle) || (state_q == StDone));
    lfsr_en  = !abort_i && (state_q == StShift);
    // The chain only holds a response after the first capture, so the first pattern's
    // shift-in is not compacted.
    misr_en  = !abort_i && (((state_q == StShift) && (pat_cnt_q != '0)) ||
                            (state_q == StUnload));
  end

  scan_lfsr_misr #(
    .Width  (LFSR_W),
    .Poly   (LFSR_POLY),
    .RstVal (LFSR_SEED)
  ) u_lfsr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (start_go),
    .load_val_i (LFSR_SEED),
    .en_i       (lfsr_en),
    .din_i      (1'b0),
    .d_o        (lfsr_d),
    .q_o        (lfsr_q)
  );

  scan_lfsr_misr #(
    .Width  (MISR_W),
    .Poly   (MISR_POLY),
    .RstVal ('0)
  ) u_misr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (start_go),
    .load_val_i ('0),
    .en_i       (misr_en),
    .din_i      (so_i),
    .d_o        (misr_d),
    .q_o        (misr_q)
  );

  // FSM, counters and registered SE/SI. SI is loaded with bit 0 of the LFSR value the
  // next cycle will hold, so each SHIFT cycle presents LFSR[0] before the LFSR steps.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      se_q      <= 1'b0;
      si_q      <= 1'b0;
      cnt_q     <= '0;
      pat_cnt_q <= '0;
    end else if (abort_i) begin
      state_q <= StIdle;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q   <= StShift;
            se_q      <= 1'b1;
            si_q      <= lfsr_d[0];
            cnt_q     <= '0;
            pat_cnt_q <= '0;
          end
        end
        StShift: begin
          if (cnt_q == LastShift) begin
            state_q <= StCapture;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            si_q  <= lfsr_d[0];
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCapture: begin
          pat_cnt_q <= pat_cnt_q + 1'b1;
          se_q      <= 1'b1;
          if (pat_cnt_q == LastPat) begin
            state_q <= StUnload;
            si_q    <= 1'b0;
          end else begin
            state_q <= StShift;
            si_q    <= lfsr_d[0];
          end
        end
        StUnload: begin
          if (cnt_q == LastShift) begin
            state_q <= StDone;
            se_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          se_q    <= 1'b0;
          si_q    <= 1'b0;
        end
      endcase
    end
  end

  // Only the LFSR's next LSB and the MISR's current value leave this block.
  logic unused_regs;
  assign unused_regs = ^{lfsr_q, lfsr_d[LFSR_W-1:1], misr_d};

  assign se_o        = se_q;
  assign si_o        = si_q;
  assign busy_o      = (state_q == StShift) || (state_q == StCapture) || (state_q == StUnload);
  assign done_o      = (state_q == StDone);
  assign signature_o = misr_q;
  assign pat_cnt_o   = pat_cnt_q;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Bench for scan_bist_ctrl with a 4-flop behavioural chain and 2 patterns per run.
module tb_scan_bist_ctrl;

  localparam int unsigned L    = 4;
  localparam int unsigned P    = 2;
  localparam int unsigned Run  = L * (P + 1) + P;
  localparam logic [15:0] Seed = 16'hACE1;
  localparam logic [15:0] Poly = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        so_rand = 1'b0;
  logic        se, si, busy, done;
  logic [15:0] sig;
  logic [1:0]  pat;
  int          so_mode = 0;  // 0: chain, 1: stuck at 0, 2: random
  logic [L-1:0] chain = '0;
  logic        so;

  int checks = 0;
  int errors = 0;

  bit          pat_bits [L*P];
  logic        se_rec   [64];
  logic        si_rec   [64];
  logic        din_rec  [64];
  logic [1:0]  pat_rec  [64];
  int          nbusy;
  logic [15:0] clean_exp;

  always #5 clk = ~clk;

  // Behavioural chain: shifts when SE, otherwise captures the inverse of its contents.
  always @(posedge clk) begin
    if (se) chain <= {chain[L-2:0], si};
    else    chain <= ~chain;
  end

  assign so = (so_mode == 0) ? chain[L-1] : (so_mode == 1) ? 1'b0 : so_rand;

  scan_bist_ctrl #(
    .CHAIN_LEN (L),
    .PATTERNS  (P)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .so_i        (so),
    .se_o        (se),
    .si_o        (si),
    .busy_o      (busy),
    .done_o      (done),
    .signature_o (sig),
    .pat_cnt_o   (pat)
  );

  // Signature of a serial stream fed into a zeroed MISR.
  function automatic logic [15:0] misr_of(input bit s[$]);
    logic [15:0] m;
    m = '0;
    foreach (s[i]) begin
      m = (m >> 1) ^ (m[0] ? Poly : 16'h0);
      m[15] = m[15] ^ s[i];
    end
    return m;
  endfunction

  // Per-run schedule: P blocks of (L shifts + 1 capture), then L unload cycles.
  function automatic bit in_unload(input int c);
    return c >= int'(P * (L + 1));
  endfunction
  function automatic bit exp_se(input int c);
    return in_unload(c) ? 1'b1 : ((c % (L + 1)) < L);
  endfunction
  function automatic bit exp_si(input int c);
    if (in_unload(c) || (c % (L + 1)) == L) return 1'b0;
    return pat_bits[(c / (L + 1)) * L + (c % (L + 1))];
  endfunction
  function automatic int exp_pat(input int c);
    return in_unload(c) ? P : c / (L + 1);
  endfunction
  function automatic bit compacts(input int c);
    return in_unload(c) || (((c % (L + 1)) < L) && (c / (L + 1)) >= 1);
  endfunction

  // Starts a run and records one sample per BUSY cycle. Optionally spams START,
  // or asserts ABORT / reset on a given BUSY cycle index and returns one cycle later.
  task automatic run_collect(input bit spam, input int abort_at, input int rst_at,
                             output bit timeout);
    bit stop;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    timeout = 1'b1;
    stop = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      if (so_mode == 2) so_rand = 1'($urandom);
      se_rec[nbusy]  = se;
      si_rec[nbusy]  = si;
      pat_rec[nbusy] = pat;
      din_rec[nbusy] = (so_mode == 2) ? so_rand : so;
      start = spam && (nbusy < int'(P * (L + 1))) && $urandom_range(0, 1) == 1;
      if (nbusy == abort_at) begin abort = 1'b1; stop = 1'b1; end
      if (nbusy == rst_at)   begin rst_n = 1'b0; stop = 1'b1; end
      nbusy++;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (stop) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({se, si, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: se/si/busy/done=%b expected 0000", {se, si, busy, done});
    end
    checks++;
    if (sig !== 16'h0) begin
      errors++;
      $display("FAIL reset_sig: got %h expected 0000", sig);
    end
    checks++;
    if (pat !== 2'd0) begin
      errors++;
      $display("FAIL reset_pat: got %0d expected 0", pat);
    end
  endtask

  task automatic test_clean_run();
    bit to;
    so_mode = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    run_collect(1'b0, -1, -1, to);
    checks++;
    if (to || nbusy != int'(Run)) begin
      errors++;
      $display("FAIL clean_busy_len: got %0d cycles expected %0d (timeout=%0d)", nbusy, Run, to);
    end
    for (int c = 0; c < int'(Run); c++) begin
      checks++;
      if (se_rec[c] !== exp_se(c) || si_rec[c] !== exp_si(c) || pat_rec[c] !== 2'(exp_pat(c)))
      begin
        errors++;
        $display("FAIL clean_trace[%0d]: se/si/pat=%b/%b/%0d expected %b/%b/%0d", c,
                 se_rec[c], si_rec[c], pat_rec[c], exp_se(c), exp_si(c), exp_pat(c));
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || se !== 1'b0 || sig !== clean_exp || pat !== 2'(P))
      begin
        errors++;
        $display("FAIL clean_done[%0d]: done=%b busy=%b se=%b sig=%h pat=%0d expected 1 0 0 %h %0d",
                 k, done, busy, se, sig, pat, clean_exp, P);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stuck0();
    bit to;
    bit zq[$];
    so_mode = 1;
    for (int i = 0; i < int'(L * P); i++) zq.push_back(1'b0);
    run_collect(1'b0, -1, -1, to);
    so_mode = 0;
    checks++;
    if (to || nbusy != int'(Run) || sig !== misr_of(zq)) begin
      errors++;
      $display("FAIL stuck0_sig: got %h after %0d cycles expected %h after %0d",
               sig, nbusy, misr_of(zq), Run);
    end
    checks++;
    if (sig === clean_exp) begin
      errors++;
      $display("FAIL stuck0_differs: got %h expected a value other than %h", sig, clean_exp);
    end
  endtask

  task automatic test_random_so();
    bit to;
    bit q[$];
    for (int r = 0; r < 3; r++) begin
      so_mode = 2;
      q = {};
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_collect(1'b0, -1, -1, to);
      for (int c = 0; c < nbusy; c++) if (compacts(c)) q.push_back(din_rec[c]);
      checks++;
      if (to || nbusy != int'(Run) || sig !== misr_of(q) || done !== 1'b1) begin
        errors++;
        $display("FAIL random_so_sig[%0d]: got %h done=%b cycles=%0d expected %h done=1 cycles=%0d",
                 r, sig, done, nbusy, misr_of(q), Run);
      end
    end
    so_mode = 0;
  endtask

  task automatic test_start_spam();
    bit to;
    so_mode = 0;
    run_collect(1'b1, -1, -1, to);
    checks++;
    if (to || nbusy != int'(Run)) begin
      errors++;
      $display("FAIL spam_busy_len: got %0d expected %0d", nbusy, Run);
    end
    checks++;
    if (sig !== clean_exp || done !== 1'b1) begin
      errors++;
      $display("FAIL spam_sig: got %h done=%b expected %h done=1", sig, done, clean_exp);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    so_mode = 0;
    run_collect(1'b0, -1, 5, to);
    checks++;
    if (to || {se, si, busy, done} !== 4'b0000 || sig !== 16'h0 || pat !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: se/si/busy/done=%b sig=%h pat=%0d expected 0000 0000 0",
               {se, si, busy, done}, sig, pat);
    end
    rst_n = 1'b1;
    run_collect(1'b0, -1, -1, to);
    checks++;
    if (to || nbusy != int'(Run) || sig !== clean_exp) begin
      errors++;
      $display("FAIL reset_rerun_sig: got %h in %0d cycles expected %h in %0d",
               sig, nbusy, clean_exp, Run);
    end
  endtask

  task automatic test_abort_unload();
    bit to;
    bit q[$];
    int a;
    so_mode = 0;
    a = $urandom_range(P * (L + 1), Run - 1);
    run_collect(1'b0, a, -1, to);
    // Compaction stops before the aborting edge: only the stream prefix is absorbed.
    for (int i = 0; i < int'(L * (P - 1)) + a - int'(P * (L + 1)); i++)
      q.push_back(~pat_bits[i]);
    checks++;
    if (to || {se, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_ctrl[%0d]: se/busy/done=%b expected 000", a, {se, busy, done});
    end
    checks++;
    if (pat !== 2'(P) || sig !== misr_of(q)) begin
      errors++;
      $display("FAIL abort_kept[%0d]: pat=%0d sig=%h expected pat=%0d sig=%h",
               a, pat, sig, P, misr_of(q));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: done=%b busy=%b expected 0 0", done, busy);
    end
    run_collect(1'b0, -1, -1, to);
    checks++;
    if (to || nbusy != int'(Run) || sig !== clean_exp || done !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun_sig: got %h done=%b expected %h done=1", sig, done, clean_exp);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    so_mode = 0;
    for (int r = 0; r < 2; r++) begin
      run_collect(1'b0, -1, -1, to);
      checks++;
      if (to || nbusy != int'(Run) || pat_rec[0] !== 2'd0 || sig !== clean_exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: cycles=%0d pat0=%0d sig=%h expected %0d 0 %h",
                 r, nbusy, pat_rec[0], sig, Run, clean_exp);
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    bit cq[$];
    v = Seed;
    for (int k = 0; k < int'(L * P); k++) begin
      pat_bits[k] = v[0];
      v = (v >> 1) ^ (v[0] ? Poly : 16'h0);
    end
    // The chain captures the inverse of each pattern and unloads it last-flop first,
    // so the compacted stream is the inverted pattern stream in generation order.
    for (int k = 0; k < int'(L * P); k++) cq.push_back(~pat_bits[k]);
    clean_exp = misr_of(cq);

    test_reset();
    test_clean_run();
    test_stuck0();
    test_random_so();
    test_start_spam();
    test_reset_mid();
    test_abort_unload();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
